neuron_layer_sequencer: RTL

Sequences one fully-connected layer over the neuron dual-port RAM. It reads N_IN input activations from the RAM read port and signed weights and biases from a weight memory, then multiply-accumulates. It rescales, applies ReLU with saturation, and writes N_OUT output activations back through the RAM write port. A start/busy/done handshake lets the top-level controller chain layers.

---
 rtl/neuron_layer_sequencer_if.sv | 27 ++
 rtl/neuron_layer_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/neuron_layer_sequencer_if.sv
// Handshake and memory-port bundle between a layer sequencer and its RAM, weight memory and controller.
// master = sequencer side, slave = environment (controller, neuron RAM, weight memory).
interface neuron_layer_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] ram_read_address;
  logic       ram_oe;
  logic [7:0] ram_read_data;
  logic [7:0] ram_write_address;
  logic [7:0] ram_write_data;
  logic       ram_wre;
  logic [7:0] w_addr;
  logic [7:0] w_data;

  modport master (
    input  start, ram_read_data, w_data,
    output busy, done, ram_read_address, ram_oe,
    output ram_write_address, ram_write_data, ram_wre, w_addr
  );

  modport slave (
    output start, ram_read_data, w_data,
    input  busy, done, ram_read_address, ram_oe,
    input  ram_write_address, ram_write_data, ram_wre, w_addr
  );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Fully-connected layer sequencer: MAC over N_IN activations per neuron, add bias,
// rescale, ReLU with saturation, write N_OUT activations back to the neuron RAM.
module neuron_layer_sequencer #(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 8,
  parameter int W_BASE   = 0,
  parameter int SHIFT    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  neuron_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_BIAS  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [6:0] I_LAST = 7'(N_IN - 1);
  localparam logic [6:0] J_LAST = 7'(N_OUT - 1);

  state_t             state_q, state_d;
  logic [6:0]         i_q, i_d;
  logic [6:0]         j_q, j_d;
  logic signed [23:0] acc_q, acc_d;

  logic signed [16:0] prod_s;
  logic [15:0]        w_row_s;
  logic [15:0]        w_sum_s;
  logic               busy_s, done_s, ram_oe_s, ram_wre_s;
  logic [7:0]         ram_read_address_s, ram_write_address_s, ram_write_data_s;

  function automatic logic [7:0] act_f(input logic signed [23:0] x);
    logic signed [23:0] y;
    y = x >>> SHIFT;
    if (y < 24'sd0) begin
      return 8'd0;
    end else if (y > 24'sd255) begin
      return 8'd255;
    end else begin
      return y[7:0];
    end
  endfunction

  // Activation is unsigned, so it is zero-extended before the signed multiply.
  assign prod_s  = $signed({8'd0, bus.ram_read_data}) * $signed({{9{bus.w_data[7]}}, bus.w_data});
  assign w_row_s = 16'(W_BASE) + 16'(j_q) * 16'(N_IN + 1);

  // Next-state, counter/accumulator update and state-decoded outputs.
  always_comb begin
    state_d             = state_q;
    i_d                 = i_q;
    j_d                 = j_q;
    acc_d               = acc_q;
    busy_s              = 1'b0;
    done_s              = 1'b0;
    ram_oe_s            = 1'b0;
    ram_wre_s           = 1'b0;
    ram_read_address_s  = 8'd0;
    ram_write_address_s = 8'd0;
    ram_write_data_s    = 8'd0;
    w_sum_s             = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          i_d     = 7'd0;
          j_d     = 7'd0;
          acc_d   = 24'sd0;
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        busy_s             = 1'b1;
        ram_oe_s           = 1'b1;
        ram_read_address_s = 8'(IN_BASE) + 8'(i_q);
        w_sum_s            = w_row_s + 16'(i_q);
        acc_d              = acc_q + {{7{prod_s[16]}}, prod_s};
        i_d                = i_q + 7'd1;
        if (i_q == I_LAST) begin
          state_d = S_BIAS;
        end else begin
          state_d = S_MAC;
        end
      end
      S_BIAS: begin
        busy_s  = 1'b1;
        w_sum_s = w_row_s + 16'(N_IN);
        acc_d   = acc_q + {{16{bus.w_data[7]}}, bus.w_data};
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy_s              = 1'b1;
        ram_wre_s           = 1'b1;
        ram_write_address_s = 8'(OUT_BASE) + 8'(j_q);
        ram_write_data_s    = act_f(acc_q);
        acc_d               = 24'sd0;
        i_d                 = 7'd0;
        if (j_q == J_LAST) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 7'd1;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and accumulator; reset mid-layer abandons the layer at that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 7'd0;
      j_q     <= 7'd0;
      acc_q   <= 24'sd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.busy              = busy_s;
  assign bus.done              = done_s;
  assign bus.ram_oe            = ram_oe_s;
  assign bus.ram_wre           = ram_wre_s;
  assign bus.ram_read_address  = ram_read_address_s;
  assign bus.ram_write_address = ram_write_address_s;
  assign bus.ram_write_data    = ram_write_data_s;
  assign bus.w_addr            = w_sum_s[7:0];

endmodule
